// File: rtl/deinterleaver_sub.sv
// ============================================================================
//  Module      : deinterleaver_sub
//  Description : Single-buffer block de-interleaver (column-in, row-out).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deinterleaver_sub #(
    parameter int WIDTH = 1,
    parameter int ROW   = 512,
    parameter int COL   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             err_tlast
);

    localparam int N  = ROW * COL;
    localparam int CW = $clog2(N) + 1;
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] c_ZERO     = '0;
    localparam logic [CW-1:0] c_ONE      = CW'(1);
    localparam logic [CW-1:0] c_COL      = CW'(COL);
    localparam logic [CW-1:0] c_N        = CW'(N);
    localparam logic [CW-1:0] c_ROW_LAST = CW'(ROW - 1);
    localparam logic [CW-1:0] c_COL_LAST = CW'(COL - 1);
    localparam logic [CW-1:0] c_IDX_LAST = CW'(N - 1);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [CW-1:0]    r_waddr;
    logic [CW-1:0]    r_raddr;
    logic [WIDTH-1:0] r_mem [0:N-1];

    logic             r_s_ready;
    logic [WIDTH-1:0] r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_err;

    logic             w_fill_beat;
    logic             w_fill_last;
    logic             w_we;
    logic             w_drain_accept;
    logic [CW-1:0]    w_raddr_inc;

    assign s_axis_tready = r_s_ready;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;
    assign err_tlast     = r_err;

    assign w_fill_beat    = (r_state == ST_FILL) && s_axis_tvalid && r_s_ready;
    assign w_fill_last    = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    assign w_we           = w_fill_beat && (r_waddr < c_N);
    assign w_drain_accept = (r_state == ST_DRAIN) && r_m_valid && m_axis_tready;
    assign w_raddr_inc    = r_raddr + c_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL:  if (w_fill_beat && w_fill_last)    w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_drain_accept && r_m_last)    w_state_next = ST_FILL;
            default:  w_state_next = ST_FILL;
        endcase
    end

    // Storage is deliberately not reset; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_waddr[AW-1:0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row     <= c_ZERO;
            r_col     <= c_ZERO;
            r_waddr   <= c_ZERO;
            r_raddr   <= c_ZERO;
            r_s_ready <= 1'b0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_fill_beat && (s_axis_tlast != w_fill_last);
            if (r_state == ST_FILL) begin
                r_s_ready <= !(w_fill_beat && w_fill_last);
                if (w_fill_beat) begin
                    if (w_fill_last) begin
                        r_row   <= c_ZERO;
                        r_col   <= c_ZERO;
                        r_waddr <= c_ZERO;
                    end else if (r_row == c_ROW_LAST) begin
                        // Column wrap: next column starts at row 0, address = column index.
                        r_row   <= c_ZERO;
                        r_col   <= r_col + c_ONE;
                        r_waddr <= r_col + c_ONE;
                    end else begin
                        r_row   <= r_row + c_ONE;
                        r_waddr <= r_waddr + c_COL;
                    end
                end
            end else begin
                if (!r_m_valid) begin
                    r_m_data  <= r_mem[0];
                    r_m_valid <= 1'b1;
                    r_m_last  <= (N == 1);
                    r_raddr   <= c_ZERO;
                end else if (m_axis_tready) begin
                    if (r_m_last) begin
                        r_m_data  <= '0;
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_raddr   <= c_ZERO;
                    end else begin
                        r_m_data <= r_mem[w_raddr_inc[AW-1:0]];
                        r_m_last <= (w_raddr_inc == c_IDX_LAST);
                        r_raddr  <= w_raddr_inc;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_deinterleaver_sub.sv
// ============================================================================
//  Module      : tb_deinterleaver_sub
//  Description : Directed, table-driven bench for deinterleaver_sub (4x3 block).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deinterleaver_sub;

    localparam int ROW = 4;
    localparam int COL = 3;
    localparam int W   = 8;
    localparam int N   = ROW * COL;

    logic         clk;
    logic         rst;
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         err_tlast;

    deinterleaver_sub #(.WIDTH(W), .ROW(ROW), .COL(COL)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .err_tlast     (err_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] din;
        logic         tlast;
        logic         exp_err;
        logic [W-1:0] exp_dout;
        logic         exp_mlast;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } obeat_t;

    vec_t   tbl [0:2*N-1];
    obeat_t oq[$];
    int     n_pass  = 0;
    int     n_total = 0;
    bit     rnd_mode = 1'b0;

    logic         prev_stall;
    logic         prev_last_acc;
    logic [W-1:0] prev_d;
    logic         prev_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Output monitor: collects accepted beats and checks stall stability and drain-side ready.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall    <= 1'b0;
            prev_last_acc <= 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {23'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                    {23'd0, 1'b1, prev_l, prev_d});
            if (prev_last_acc) chk("refill_ready", 32'(s_axis_tready), 32'd1);
            if (m_axis_tvalid) chk("no_in_during_drain", 32'(s_axis_tready), 32'd0);
            prev_stall    <= m_axis_tvalid && !m_axis_tready;
            prev_last_acc <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
            prev_d        <= m_axis_tdata;
            prev_l        <= m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) oq.push_back('{d: m_axis_tdata, l: m_axis_tlast});
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Called and returns on a falling edge; leaves valid high when hold is set.
    task automatic send_vecs(input int base, input bit hold);
        int budget;
        for (int i = 0; i < N; i++) begin
            s_axis_tdata  = tbl[base+i].din;
            s_axis_tlast  = tbl[base+i].tlast;
            s_axis_tvalid = 1'b1;
            budget = 0;
            while (!s_axis_tready && budget < 200) begin
                @(negedge clk);
                budget++;
            end
            if (!s_axis_tready) begin
                chk("send_timeout", 32'd0, 32'd1);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(negedge clk);
            chk("err_tlast", 32'(err_tlast), 32'(tbl[base+i].exp_err));
        end
        if (!hold) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    task automatic expect_outputs(input int base);
        int budget;
        obeat_t b;
        budget = 0;
        while (oq.size() < N && budget < 400) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (oq.size() < N) begin
            chk("out_timeout", 32'(oq.size()), 32'(N));
            oq.delete();
            return;
        end
        for (int i = 0; i < N; i++) begin
            b = oq.pop_front();
            chk("dout", {23'd0, b.l, b.d}, {23'd0, tbl[base+i].exp_mlast, tbl[base+i].exp_dout});
        end
    endtask

    task automatic check_idle_zero(input string name);
        chk(name, {20'd0, s_axis_tready, m_axis_tvalid, m_axis_tlast, err_tlast, m_axis_tdata}, 32'd0);
    endtask

    initial begin
        int ord [0:N-1] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
        int budget;
        for (int i = 0; i < N; i++) begin
            tbl[i]   = '{din: W'(ord[i]), tlast: (i == N-1), exp_err: 1'b0,
                         exp_dout: W'(i), exp_mlast: (i == N-1)};
            tbl[N+i] = '{din: W'(ord[i]), tlast: (i == N-2), exp_err: (i >= N-2),
                         exp_dout: W'(i), exp_mlast: (i == N-1)};
        end

        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset_state");
        rst = 1'b0;
        #1;
        chk("ready_before_edge", 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(s_axis_tready), 32'd1);

        // Basic block with latency check
        send_vecs(0, 1'b0);
        chk("lat_edge1_valid", 32'(m_axis_tvalid), 32'd0);
        chk("lat_edge1_ready", 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        chk("lat_edge2_valid", 32'(m_axis_tvalid), 32'd1);
        expect_outputs(0);
        repeat (5) @(negedge clk);
        chk("no_extra_out", 32'(oq.size()), 32'd0);

        // Random backpressure
        rnd_mode = 1'b1;
        send_vecs(0, 1'b0);
        expect_outputs(0);
        rnd_mode = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_extra_out_rnd", 32'(oq.size()), 32'd0);

        // Three back-to-back blocks with valid held high
        for (int b = 0; b < 3; b++) send_vecs(0, 1'b1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int b = 0; b < 3; b++) expect_outputs(0);
        repeat (5) @(negedge clk);
        chk("no_extra_out_b2b", 32'(oq.size()), 32'd0);

        // Misplaced upstream tlast
        send_vecs(N, 1'b0);
        expect_outputs(N);
        repeat (3) @(negedge clk);

        // Reset mid-drain
        send_vecs(0, 1'b0);
        budget = 0;
        while (oq.size() < 6 && budget < 100) begin
            @(negedge clk);
            #1;
            budget++;
        end
        chk("six_outputs_seen", 32'(oq.size() >= 6), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_zero("reset_mid_drain");
        repeat (2) @(negedge clk);
        check_idle_zero("reset_held");
        rst = 1'b0;
        oq.delete();
        @(negedge clk);
        chk("ready_after_rst", 32'(s_axis_tready), 32'd1);
        send_vecs(0, 1'b0);
        expect_outputs(0);
        repeat (5) @(negedge clk);
        chk("no_extra_out_rst", 32'(oq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
